// File: rtl/cix.sv
// cix: registered population count / leading-zero / trailing-zero unit.
// Ports: clk, rst_n (async low), op, in, in_valid -> out, flag, out_valid.
`ifndef CIX_OPS
`define CIX_OPS
`define CIX_PCNT 2'd0
`define CIX_CLZ  2'd1
`define CIX_CTZ  2'd2
`endif

module cix #(
   parameter int ORDER = 3,
   localparam int W = 2**ORDER
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       op,
   input  logic [W-1:0]     in,
   input  logic             in_valid,
   output logic [ORDER:0]   out,
   output logic             flag,
   output logic             out_valid
);

   // Pairwise adder tree, one level per loop pass (log2 W levels).
   function automatic logic [ORDER:0] f_pcnt(input logic [W-1:0] v);
      logic [ORDER:0] a [W];
      for (int i = 0; i < W; i++)
         a[i] = {{ORDER{1'b0}}, v[i]};
      for (int l = 0; l < ORDER; l++)
         for (int i = 0; i < (W >> (l + 1)); i++)
            a[i] = a[2*i] + a[2*i+1];
      return a[0];
   endfunction

   // Leading-zero merge: each node carries an all-zero flag and a count.
   // If the upper half is all zero, the count is half size plus the lower
   // half's count; otherwise it is the upper half's count.
   // Returns {all_zero, count}.
   function automatic logic [ORDER+1:0] f_clz(input logic [W-1:0] v);
      logic [ORDER:0] c [W];
      logic           z [W];
      logic [ORDER:0] s;
      for (int i = 0; i < W; i++) begin
         z[i] = ~v[i];
         c[i] = {{ORDER{1'b0}}, ~v[i]};
      end
      for (int l = 0; l < ORDER; l++) begin
         s = (ORDER+1)'(1) << l;
         for (int i = 0; i < (W >> (l + 1)); i++) begin
            c[i] = z[2*i+1] ? s + c[2*i] : c[2*i+1];
            z[i] = z[2*i+1] & z[2*i];
         end
      end
      return {z[0], c[0]};
   endfunction

   logic [W-1:0]   rev;
   logic [ORDER:0] pcnt_res;
   logic [ORDER+1:0] clz_res;
   logic [ORDER+1:0] ctz_res;
   logic [ORDER:0] out_d;
   logic           flag_d;

   always_comb begin
      rev = '0;
      for (int i = 0; i < W; i++)
         rev[i] = in[W-1-i];
      pcnt_res = f_pcnt(in);
      clz_res  = f_clz(in);
      // Trailing zeros are leading zeros of the mirrored operand.
      ctz_res  = f_clz(rev);
      out_d  = '0;
      flag_d = 1'b0;
      case (op)
         `CIX_PCNT: begin
            out_d  = pcnt_res;
            flag_d = &in;
         end
         `CIX_CLZ: begin
            out_d  = clz_res[ORDER:0];
            flag_d = clz_res[ORDER+1];
         end
         `CIX_CTZ: begin
            out_d  = ctz_res[ORDER:0];
            flag_d = ctz_res[ORDER+1];
         end
         default: begin
            out_d  = '0;
            flag_d = 1'b0;
         end
      endcase
   end

   // Results hold while idle; only the qualifier drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         flag      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out  <= out_d;
            flag <= flag_d;
         end
      end
   end

endmodule

// File: tb/tb_cix.sv
// tb_cix: directed + exhaustive scoreboard bench for cix at ORDER=3.
// Expected results are queued at drive time and popped on out_valid.
`ifndef CIX_OPS
`define CIX_OPS
`define CIX_PCNT 2'd0
`define CIX_CLZ  2'd1
`define CIX_CTZ  2'd2
`endif

module tb_cix;

   logic       clk;
   logic       rst_n;
   logic [1:0] op;
   logic [7:0] in;
   logic       in_valid;
   logic [3:0] out;
   logic       flag;
   logic       out_valid;

   cix #(.ORDER(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op        (op),
      .in        (in),
      .in_valid  (in_valid),
      .out       (out),
      .flag      (flag),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] o;
      logic       f;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   logic [3:0] last_o = '0;
   logic       last_f = 1'b0;

   function automatic logic [3:0] ref_pcnt(input logic [7:0] v);
      logic [3:0] n = 0;
      for (int i = 0; i < 8; i++)
         if (v[i]) n++;
      return n;
   endfunction

   function automatic logic [3:0] ref_clz(input logic [7:0] v);
      logic [3:0] n = 0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) break;
         n++;
      end
      return n;
   endfunction

   function automatic logic [3:0] ref_ctz(input logic [7:0] v);
      logic [3:0] n = 0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) break;
         n++;
      end
      return n;
   endfunction

   function automatic exp_t ref_model(input logic [1:0] o, input logic [7:0] v);
      exp_t e;
      e.o = 4'd0;
      e.f = 1'b0;
      if (o == `CIX_PCNT) begin
         e.o = ref_pcnt(v);
         e.f = (v == 8'hFF);
      end else if (o == `CIX_CLZ) begin
         e.o = ref_clz(v);
         e.f = (v == 8'h00);
      end else if (o == `CIX_CTZ) begin
         e.o = ref_ctz(v);
         e.f = (v == 8'h00);
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle; on valid, queue the given expectation.
   task automatic step_k(input logic [1:0] o, input logic [7:0] v,
                         input logic vld, input logic [3:0] eo,
                         input logic ef, input string tag);
      exp_t e;
      @(negedge clk);
      op       = o;
      in       = v;
      in_valid = vld;
      if (vld) begin
         e.o = eo;
         e.f = ef;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, vld});
      if (out_valid) begin
         if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk({tag, ".out"}, {28'd0, out}, {28'd0, e.o});
            chk({tag, ".flag"}, {31'd0, flag}, {31'd0, e.f});
            last_o = e.o;
            last_f = e.f;
         end
      end else begin
         chk({tag, ".hold_out"}, {28'd0, out}, {28'd0, last_o});
         chk({tag, ".hold_flag"}, {31'd0, flag}, {31'd0, last_f});
      end
   endtask

   task automatic step(input logic [1:0] o, input logic [7:0] v,
                       input logic vld, input string tag);
      exp_t e;
      e = ref_model(o, v);
      step_k(o, v, vld, e.o, e.f, tag);
   endtask

   initial begin
      rst_n    = 1'b0;
      op       = 2'd0;
      in       = 8'd0;
      in_valid = 1'b0;
      #2;
      chk("rst.out", {28'd0, out}, 32'd0);
      chk("rst.flag", {31'd0, flag}, 32'd0);
      chk("rst.valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Boundaries with fixed expectations
      step_k(`CIX_PCNT, 8'h00, 1'b1, 4'd0, 1'b0, "b00.pcnt");
      step_k(`CIX_CLZ,  8'h00, 1'b1, 4'd8, 1'b1, "b00.clz");
      step_k(`CIX_CTZ,  8'h00, 1'b1, 4'd8, 1'b1, "b00.ctz");
      step_k(`CIX_PCNT, 8'hFF, 1'b1, 4'd8, 1'b1, "bff.pcnt");
      step_k(`CIX_CLZ,  8'hFF, 1'b1, 4'd0, 1'b0, "bff.clz");
      step_k(`CIX_CTZ,  8'hFF, 1'b1, 4'd0, 1'b0, "bff.ctz");
      step_k(`CIX_CLZ,  8'h80, 1'b1, 4'd0, 1'b0, "b80.clz");
      step_k(`CIX_CTZ,  8'h80, 1'b1, 4'd7, 1'b0, "b80.ctz");
      step_k(`CIX_CLZ,  8'h01, 1'b1, 4'd7, 1'b0, "b01.clz");
      step_k(`CIX_CTZ,  8'h01, 1'b1, 4'd0, 1'b0, "b01.ctz");
      step_k(`CIX_CLZ,  8'h10, 1'b1, 4'd3, 1'b0, "b10.clz");
      step_k(`CIX_CTZ,  8'h10, 1'b1, 4'd4, 1'b0, "b10.ctz");
      step_k(`CIX_PCNT, 8'h10, 1'b1, 4'd1, 1'b0, "b10.pcnt");
      step_k(2'd3,      8'hA5, 1'b1, 4'd0, 1'b0, "rsv");

      // Handshake gap: 1,0,1
      step_k(`CIX_PCNT, 8'h0F, 1'b1, 4'd4, 1'b0, "hs.a");
      step_k(`CIX_CLZ,  8'h33, 1'b0, 4'd0, 1'b0, "hs.gap");
      step_k(`CIX_CLZ,  8'h10, 1'b1, 4'd3, 1'b0, "hs.b");

      // Exhaustive sweep against bit-loop models
      for (int o = 0; o < 3; o++)
         for (int v = 0; v < 256; v++)
            step(o[1:0], v[7:0], 1'b1, "sweep");

      // Mid-cycle reset while a result is valid
      step_k(`CIX_PCNT, 8'hFF, 1'b1, 4'd8, 1'b1, "pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst.out", {28'd0, out}, 32'd0);
      chk("mrst.flag", {31'd0, flag}, 32'd0);
      chk("mrst.valid", {31'd0, out_valid}, 32'd0);
      sb.delete();
      last_o = '0;
      last_f = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step_k(`CIX_CTZ, 8'h0F, 1'b0, 4'd0, 1'b0, "post.idle");
      step_k(`CIX_CTZ, 8'h0F, 1'b1, 4'd0, 1'b0, "post.ctz");
      step_k(`CIX_CLZ, 8'h0F, 1'b0, 4'd0, 1'b0, "post.hold");

      chk("sb.drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
